// File: rtl/convolve_audio_fir_pkg.sv
// Shared types and helpers for the sample-serial FIR convolver.
package convolve_pkg;

  typedef enum logic [2:0] {CLEAR, IDLE, CONVOLVING, DRAIN, OUTPUT} conv_state_t;

  localparam int RAM_LATENCY = 2;
  localparam int MAC_LATENCY = 1;
  localparam int PIPE_STAGES = RAM_LATENCY + MAC_LATENCY;

  // Clamp a signed value into a w-bit signed range; caller truncates to w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_tap_ram.sv
// Simple dual-port tap memory: one write port, one read port, 2-cycle registered read.
module fir_tap_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
) (
  input  logic                     audio_clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0]         mem [DEPTH];
  logic [$clog2(DEPTH)-1:0] rd_addr_q;

  always_ff @(posedge audio_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_addr_q <= rd_addr;
    rd_data   <= mem[rd_addr_q];
  end

endmodule

// File: rtl/convolve_audio_fir.sv
// Sample-serial FIR convolver: one time-multiplexed MAC walks the impulse per trigger,
// with dry bypass until the impulse response is marked complete.
module convolve_audio_fir
  import convolve_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int MAX_TAPS  = 1024,
  parameter int ACC_W     = 48,
  parameter int OUT_SHIFT = 32
) (
  input  logic                        audio_clk,
  input  logic                        rst_n_in,
  input  logic                        audio_trigger,
  input  logic [DATA_W-1:0]           audio_in,
  input  logic [15:0]                 impulse_length,
  input  logic                        impulse_complete,
  input  logic                        coef_wr_en,
  input  logic [$clog2(MAX_TAPS)-1:0] coef_wr_addr,
  input  logic [COEF_W-1:0]           coef_wr_data,
  output logic [DATA_W-1:0]           convolved_audio,
  output logic                        audio_valid_out,
  output logic                        busy,
  output logic                        overrun
);

  localparam int AW = $clog2(MAX_TAPS);
  localparam int LW = AW + 1;

  // Async assert, synchronous release.
  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge audio_clk or negedge rst_n_in)
    if (!rst_n_in) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];

  conv_state_t                  state, state_nx;
  logic [AW-1:0]                wp;
  logic [LW-1:0]                k, len_q, len_in;
  logic                         accept, bypass_q;
  logic [DATA_W-1:0]            dry_q;
  logic signed [ACC_W-1:0]      acc, acc_shr;
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic [PIPE_STAGES:1]         vld_q;
  logic [PIPE_STAGES:0]         vld_pipe;
  logic                         hist_we, coef_we;
  logic [AW-1:0]                hist_wa;
  logic [DATA_W-1:0]            hist_wd, hist_rd;
  logic [COEF_W-1:0]            coef_rd;

  assign len_in   = (32'(impulse_length) > MAX_TAPS) ? LW'(MAX_TAPS) : LW'(impulse_length);
  assign vld_pipe = {vld_q, state == CONVOLVING};
  assign acc_shr  = acc >>> OUT_SHIFT;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      CLEAR:      if (k == LW'(MAX_TAPS - 1)) state_nx = IDLE;
      IDLE: if (audio_trigger) begin
        accept   = 1'b1;
        state_nx = (!impulse_complete || len_in == '0) ? OUTPUT : CONVOLVING;
      end
      CONVOLVING: if (k == len_q - LW'(1)) state_nx = DRAIN;
      DRAIN:      if (k == LW'(PIPE_STAGES - 1)) state_nx = OUTPUT;
      OUTPUT:     state_nx = IDLE;
      default:    state_nx = CLEAR;
    endcase
  end

  // History port is shared between the CLEAR sweep and sample capture.
  assign hist_we = (state == CLEAR) || accept;
  assign hist_wa = (state == CLEAR) ? k[AW-1:0] : wp;
  assign hist_wd = (state == CLEAR) ? '0 : audio_in;
  assign coef_we = coef_wr_en && (state == CLEAR || state == IDLE);

  fir_tap_ram #(.WIDTH(DATA_W), .DEPTH(MAX_TAPS)) u_hist_ram (
    .audio_clk (audio_clk),
    .wr_en     (hist_we),
    .wr_addr   (hist_wa),
    .wr_data   (hist_wd),
    .rd_addr   (wp - k[AW-1:0]),
    .rd_data   (hist_rd)
  );

  fir_tap_ram #(.WIDTH(COEF_W), .DEPTH(MAX_TAPS)) u_coef_ram (
    .audio_clk (audio_clk),
    .wr_en     (coef_we),
    .wr_addr   (coef_wr_addr),
    .wr_data   (coef_wr_data),
    .rd_addr   (k[AW-1:0]),
    .rd_data   (coef_rd)
  );

  always_ff @(posedge audio_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= CLEAR;
      k               <= '0;
      wp              <= '0;
      len_q           <= '0;
      bypass_q        <= 1'b0;
      dry_q           <= '0;
      acc             <= '0;
      prod            <= '0;
      vld_q           <= '0;
      convolved_audio <= '0;
      audio_valid_out <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      state           <= state_nx;
      busy            <= state_nx != IDLE;
      k               <= (state_nx != state) ? '0 : k + LW'(1);
      vld_q           <= vld_pipe[PIPE_STAGES-1:0];
      prod            <= $signed(coef_rd) * $signed(hist_rd);
      audio_valid_out <= 1'b0;
      if (audio_trigger && state != IDLE) overrun <= 1'b1;
      if (accept) begin
        len_q    <= len_in;
        bypass_q <= !impulse_complete;
        dry_q    <= audio_in;
        acc      <= '0;
      end else if (vld_pipe[PIPE_STAGES]) begin
        acc <= acc + ACC_W'(prod);
      end
      if (state == OUTPUT) begin
        convolved_audio <= bypass_q ? dry_q : DATA_W'(saturate(64'(acc_shr), DATA_W));
        audio_valid_out <= 1'b1;
        wp              <= wp + AW'(1);
      end
    end
  end

endmodule
